shared_reg_arbiter: RTL

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

---
 rtl/shared_reg_arbiter_pkg.sv | 23 ++
 rtl/shared_reg_arbiter_rr_pick.sv | 45 ++++
 rtl/shared_reg_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/shared_reg_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shared_reg_arbiter_pkg
//  Description : Shared types and default sizing for the shared-register
//                write-port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package shared_reg_arbiter_pkg;

    localparam int NUM_REQ_DEF  = 4;
    localparam int DATA_W_DEF   = 8;
    localparam int MAX_HOLD_DEF = 4;

    // Wide enough for the largest legal MAX_HOLD (15)
    localparam int HOLD_W       = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage : shared_reg_arbiter_pkg
`default_nettype wire

// File: rtl/shared_reg_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin search. Grants the first set bit
//                of req at or above ptr, wrapping from N-1 back to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import shared_reg_arbiter_pkg::*;
#(
    parameter int N     = NUM_REQ_DEF,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    // Walk offsets from farthest to nearest so the nearest request wins
    always_comb begin
        logic [IDX_W:0]   w_sum;
        logic [IDX_W-1:0] w_idx;
        gnt     = '0;
        gnt_idx = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (w_sum >= (IDX_W + 1)'(N)) begin
                w_sum = w_sum - (IDX_W + 1)'(N);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (req[w_idx]) begin
                gnt        = '0;
                gnt[w_idx] = 1'b1;
                gnt_idx    = w_idx;
            end
        end
        any = |req;
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : shared_reg_arbiter
//  Description : Round-robin arbiter for one shared register write port with
//                optional bounded lock (burst ownership) per requester.
//                Write outputs are registered, one cycle after acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ-1:0]         req_lock_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       wr_en_o,
    output logic [DATA_W-1:0]          wr_data_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                       locked_o
);

    localparam int                IDX_W      = $clog2(NUM_REQ);
    localparam logic [HOLD_W-1:0] c_MAX_HOLD = HOLD_W'(MAX_HOLD);
    localparam bit                c_CAN_LOCK = (MAX_HOLD > 1);
    localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_t        r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_owner;
    logic [HOLD_W-1:0] r_hold_cnt;

    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic [NUM_REQ-1:0] w_ready;
    logic [IDX_W-1:0]   w_win_idx;
    logic [IDX_W-1:0]   w_next_ptr;
    logic [DATA_W-1:0]  w_win_data;
    logic               w_accept;
    logic               w_win_lock;
    logic [HOLD_W-1:0]  w_hold_inc;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req     (req_valid_i),
        .ptr     (r_ptr),
        .gnt     (w_pick_gnt),
        .gnt_idx (w_pick_idx),
        .any     (w_pick_any)
    );

    // Grant: round-robin pick when idle, only the owner (if valid) when locked
    always_comb begin
        w_ready = '0;
        if (r_state == IDLE) begin
            w_ready = w_pick_any ? w_pick_gnt : '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (IDX_W'(i) == r_owner) begin
                    w_ready[i] = req_valid_i[i];
                end
            end
        end
    end

    // Winner index, its data, and the pointer value that follows it
    always_comb begin
        w_win_idx  = (r_state == IDLE) ? w_pick_idx : r_owner;
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == w_win_idx) begin
                w_win_data = req_data_i[i*DATA_W +: DATA_W];
            end
        end
        w_next_ptr = (w_win_idx == c_LAST_IDX) ? '0 : w_win_idx + 1'b1;
        w_win_lock = req_lock_i[w_win_idx];
        w_accept   = |w_ready;
        w_hold_inc = r_hold_cnt + 1'b1;
    end

    assign req_ready_o = w_ready;
    assign locked_o    = (r_state == LOCKED);
    assign owner_o     = r_owner;

    // Arbitration state and registered write outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_hold_cnt <= '0;
            wr_en_o    <= 1'b0;
            wr_data_o  <= '0;
        end else begin
            wr_en_o <= w_accept;
            if (w_accept) begin
                wr_data_o <= w_win_data;
                r_owner   <= w_win_idx;
            end
            if (r_state == IDLE) begin
                if (w_accept) begin
                    if (w_win_lock && c_CAN_LOCK) begin
                        r_state    <= LOCKED;
                        r_hold_cnt <= HOLD_W'(1);
                    end else begin
                        r_ptr <= w_next_ptr;
                    end
                end
            end else begin
                if (w_accept && w_win_lock && (w_hold_inc < c_MAX_HOLD)) begin
                    r_hold_cnt <= w_hold_inc;
                end else begin
                    // Voluntary release, hold limit reached, or owner went idle
                    r_state    <= IDLE;
                    r_ptr      <= w_next_ptr;
                    r_hold_cnt <= '0;
                end
            end
        end
    end

endmodule : shared_reg_arbiter
`default_nettype wire
